imem_loader: RTL

Boot-time instruction-memory loader for the single-cycle RISC-V core. It takes a little-endian byte stream from the host link, assembles it into 32-bit words and writes them into instruction memory. When the image is complete it asserts `loader_done`, which drives the PC register's `loader_done_in` stall input, so the core begins fetching from address 0 only after the whole program is resident.

---
 rtl/imem_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles a little-endian byte stream into words and writes them to imem.
// Optional trailing checksum is enabled with the IMEM_LOADER_CHECKSUM_EN macro.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        loader_done,
  output logic        loader_err,
  output logic [31:0] words_loaded
);

  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM = 3'd2;
`endif
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic [2:0]  state;
  logic [1:0]  lane;
  logic [23:0] asm_bytes;
  logic [31:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`endif

  logic        accept;
  logic        last_byte;
  logic [31:0] word_full;

  // The 4th byte never lands in the assembly register; it completes the word directly.
  assign accept    = in_valid && in_ready;
  assign last_byte = (lane == 2'd3);
  assign word_full = {in_data, asm_bytes};
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready  = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
`else
  assign in_ready  = (state == ST_HDR) || (state == ST_DATA);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_HDR;
      lane         <= 2'd0;
      asm_bytes    <= 24'd0;
      word_count   <= 32'd0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      loader_done  <= 1'b0;
      loader_err   <= 1'b0;
      words_loaded <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum          <= 32'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      // Entering DONE from DATA delays loader_done by a cycle so it trails the final write.
      if (state == ST_DONE) loader_done <= 1'b1;
      if (accept) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0:    asm_bytes[7:0]   <= in_data;
          2'd1:    asm_bytes[15:8]  <= in_data;
          2'd2:    asm_bytes[23:16] <= in_data;
          default: ;
        endcase
        if (last_byte) begin
          case (state)
            ST_HDR: begin
              if (word_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= ST_CSUM;
`else
                state       <= ST_DONE;
                loader_done <= 1'b1;
`endif
              end else if (word_full > 32'(DEPTH)) begin
                state      <= ST_ERR;
                loader_err <= 1'b1;
              end else begin
                word_count <= word_full;
                state      <= ST_DATA;
              end
            end
            ST_DATA: begin
              mem_we       <= 1'b1;
              mem_addr     <= BASE_ADDR + {words_loaded[29:0], 2'b00};
              mem_wdata    <= word_full;
              words_loaded <= words_loaded + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum <= sum + word_full;
              if (words_loaded == word_count - 32'd1) state <= ST_CSUM;
`else
              if (words_loaded == word_count - 32'd1) state <= ST_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
              if (word_full == sum) begin
                state       <= ST_DONE;
                loader_done <= 1'b1;
              end else begin
                state      <= ST_ERR;
                loader_err <= 1'b1;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

endmodule
